// File: rtl/uart_tx_mmio_pkg.sv
// uart_tx_mmio_pkg
// Shared definitions for the memory-mapped UART transmitter:
//   - register byte offsets within the peripheral window
//   - STATUS register bit positions
//   - 8N1 frame length in bit periods
//   - transmit FSM state encoding
package uart_tx_mmio_pkg;

  // Register byte offsets; only address[3:2] is decoded.
  localparam logic [3:0] UART_TXDATA = 4'h0;
  localparam logic [3:0] UART_STATUS = 4'h4;

  // STATUS bit positions.
  localparam int STAT_FULL      = 0;
  localparam int STAT_EMPTY     = 1;
  localparam int STAT_BUSY      = 2;
  localparam int STAT_OVERFLOW  = 3;
  localparam int STAT_LEVEL_LSB = 8;

  // One start bit, eight data bits, one stop bit.
  localparam int UART_FRAME_BITS = 10;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  // Word index of a byte offset (the low two bits are don't-care).
  function automatic logic [1:0] reg_word(input logic [3:0] offset);
    return offset[3:2];
  endfunction

endpackage

// File: rtl/uart_tx_mmio_sync_fifo.sv
// sync_fifo
// Single-clock FIFO with first-word-fall-through read data.
// Ports:
//   clk, reset_n   : clock and synchronous active-low reset
//   push/push_data : write request; ignored while full
//   pop/pop_data   : read request; pop_data is the head entry, valid while !empty
//   full, empty    : occupancy flags
//   level          : number of stored entries, 0..DEPTH
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      level_reg;
  logic             push_ok;
  logic             pop_ok;

  assign full     = (level_reg == (AW+1)'(DEPTH));
  assign empty    = (level_reg == '0);
  assign level    = level_reg;
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;
  // The head is read combinationally so the consumer can load it on the
  // same edge it pops, keeping the transmitter's start latency at one cycle.
  assign pop_data = mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  // Pointers are exactly AW bits wide and wrap on their own.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   level_reg <= level_reg + 1'b1;
        2'b01:   level_reg <= level_reg - 1'b1;
        default: level_reg <= level_reg;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio
// Memory-mapped 8N1 UART transmitter with an 8-entry TX FIFO.
// Ports:
//   clk, reset_n      : clock and synchronous active-low reset
//   write_enable      : one-cycle write request
//   read_enable       : one-cycle read request (ignored if write_enable is high)
//   address[3:0]      : byte offset; 0x0 TXDATA, 0x4 STATUS, others unmapped
//   data_in[31:0]     : write data
//   data_out[31:0]    : read data, valid only while mem_ready is high, else 0
//   mem_ready         : one-cycle acknowledge, the cycle after each request
//   uart_tx           : serial output, idle high
module uart_tx_mmio
  import uart_tx_mmio_pkg::*;
#(
  parameter int CLK_FREQ   = 27000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        write_enable,
  input  logic        read_enable,
  input  logic [3:0]  address,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        mem_ready,
  output logic        uart_tx
);

  localparam int DIVISOR = CLK_FREQ / BAUD;
  localparam int CNT_W   = $clog2(DIVISOR + 1);
  localparam int LVL_W   = $clog2(FIFO_DEPTH) + 1;

  // Bus side
  logic        mem_ready_reg;
  logic [31:0] data_out_reg;
  logic        overflow_reg;
  logic        wr_txdata;
  logic        wr_status;
  logic        rd_req;
  logic [31:0] status_word;
  logic [31:0] read_mux;

  // FIFO
  logic [7:0]       fifo_head;
  logic             fifo_full;
  logic             fifo_empty;
  logic [LVL_W-1:0] fifo_level;
  logic             fifo_pop;

  // Transmitter
  tx_state_t        state_reg;
  logic [CNT_W-1:0] baud_cnt_reg;
  logic [2:0]       bit_idx_reg;
  logic [7:0]       shift_reg;
  logic             tx_reg;
  logic             baud_done;

  logic unused_bits;
  assign unused_bits = &{1'b0, address[1:0], data_in[31:8]};

  assign wr_txdata = write_enable && (reg_word(address) == reg_word(UART_TXDATA));
  assign wr_status = write_enable && (reg_word(address) == reg_word(UART_STATUS));
  // A write takes priority over a simultaneous read.
  assign rd_req    = read_enable && !write_enable;

  always_comb begin
    status_word                               = '0;
    status_word[STAT_FULL]                    = fifo_full;
    status_word[STAT_EMPTY]                   = fifo_empty;
    status_word[STAT_BUSY]                    = (state_reg != TX_IDLE);
    status_word[STAT_OVERFLOW]                = overflow_reg;
    status_word[STAT_LEVEL_LSB +: LVL_W]      = fifo_level;
  end

  always_comb begin
    read_mux = '0;
    if (reg_word(address) == reg_word(UART_STATUS)) begin
      read_mux = status_word;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mem_ready_reg <= 1'b0;
      data_out_reg  <= '0;
      overflow_reg  <= 1'b0;
    end else begin
      mem_ready_reg <= write_enable || read_enable;
      data_out_reg  <= rd_req ? read_mux : '0;
      // Fullness is the pre-pop value, so a byte written while full is
      // dropped even when the transmitter frees a slot this same cycle.
      if (wr_txdata && fifo_full) begin
        overflow_reg <= 1'b1;
      end else if (wr_status && data_in[STAT_OVERFLOW]) begin
        overflow_reg <= 1'b0;
      end
    end
  end

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (wr_txdata),
    .push_data (data_in[7:0]),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  assign baud_done = (baud_cnt_reg == CNT_W'(DIVISOR - 1));
  // Pop happens on the same edge the FSM loads fifo_head into shift_reg.
  assign fifo_pop  = !fifo_empty &&
                     ((state_reg == TX_IDLE) || ((state_reg == TX_STOP) && baud_done));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg    <= TX_IDLE;
      baud_cnt_reg <= '0;
      bit_idx_reg  <= '0;
      shift_reg    <= '0;
      tx_reg       <= 1'b1;
    end else begin
      case (state_reg)
        TX_IDLE: begin
          baud_cnt_reg <= '0;
          tx_reg       <= 1'b1;
          if (!fifo_empty) begin
            shift_reg <= fifo_head;
            tx_reg    <= 1'b0;
            state_reg <= TX_START;
          end
        end
        TX_START: begin
          if (baud_done) begin
            baud_cnt_reg <= '0;
            bit_idx_reg  <= '0;
            tx_reg       <= shift_reg[0];
            state_reg    <= TX_DATA;
          end else begin
            baud_cnt_reg <= baud_cnt_reg + 1'b1;
          end
        end
        TX_DATA: begin
          if (baud_done) begin
            baud_cnt_reg <= '0;
            if (bit_idx_reg == 3'd7) begin
              tx_reg    <= 1'b1;
              state_reg <= TX_STOP;
            end else begin
              // Shift right so the next bit is always at position 1 now.
              shift_reg   <= shift_reg >> 1;
              tx_reg      <= shift_reg[1];
              bit_idx_reg <= bit_idx_reg + 1'b1;
            end
          end else begin
            baud_cnt_reg <= baud_cnt_reg + 1'b1;
          end
        end
        TX_STOP: begin
          if (baud_done) begin
            baud_cnt_reg <= '0;
            if (!fifo_empty) begin
              shift_reg <= fifo_head;
              tx_reg    <= 1'b0;
              state_reg <= TX_START;
            end else begin
              state_reg <= TX_IDLE;
            end
          end else begin
            baud_cnt_reg <= baud_cnt_reg + 1'b1;
          end
        end
        default: begin
          state_reg <= TX_IDLE;
          tx_reg    <= 1'b1;
        end
      endcase
    end
  end

  assign mem_ready = mem_ready_reg;
  assign data_out  = data_out_reg;
  assign uart_tx   = tx_reg;

endmodule

// File: tb/tb_uart_tx_mmio.sv
`timescale 1ns/1ps
// tb_uart_tx_mmio
// Directed bench: a register-access vector table followed by hand-written
// sequences for frame timing, back-to-back frames, overflow, reset and the
// simultaneous read/write case.
module tb_uart_tx_mmio;

  localparam int DIVISOR = 27000000 / 115200;  // 234
  localparam int FRAME   = 10 * DIVISOR;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        write_enable = 1'b0;
  logic        read_enable = 1'b0;
  logic [3:0]  address = 4'h0;
  logic [31:0] data_in = 32'h0;
  logic [31:0] data_out;
  logic        mem_ready;
  logic        uart_tx;

  int n_checks = 0;
  int n_fail   = 0;

  uart_tx_mmio dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .write_enable (write_enable),
    .read_enable  (read_enable),
    .address      (address),
    .data_in      (data_in),
    .data_out     (data_out),
    .mem_ready    (mem_ready),
    .uart_tx      (uart_tx)
  );

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        we;
    logic        re;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_data;
    string       name;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Issue one request at the current negedge; return what the bus shows
  // one cycle later.
  task automatic bus_access(input logic we, input logic re, input logic [3:0] a,
                            input logic [31:0] d, output logic [31:0] rd, output logic rdy);
    write_enable = we;
    read_enable  = re;
    address      = a;
    data_in      = d;
    @(negedge clk);
    rdy          = mem_ready;
    rd           = data_out;
    write_enable = 1'b0;
    read_enable  = 1'b0;
    data_in      = 32'h0;
    $display("bus we=%0b re=%0b addr=0x%0h wdata=0x%08h -> ready=%0b rdata=0x%08h",
             we, re, a, d, rdy, rd);
  endtask

  task automatic read_status(input string name, input logic [31:0] exp);
    logic [31:0] rd;
    logic        rdy;
    bus_access(1'b0, 1'b1, 4'h4, 32'h0, rd, rdy);
    check({name, "_ready"}, {31'h0, rdy}, 32'h1);
    check(name, rd, exp);
  endtask

  task automatic write_reg(input logic [3:0] a, input logic [31:0] d);
    logic [31:0] rd;
    logic        rdy;
    bus_access(1'b1, 1'b0, a, d, rd, rdy);
  endtask

  // Wait up to max_wait cycles for a start bit, then compare every cycle of
  // the frame against the ideal 8N1 waveform for byte b.
  task automatic check_frame(input logic [7:0] b, input int max_wait, input string name);
    int   waited = 0;
    int   bad = -1;
    logic got = 1'b0;
    logic exp_bit;
    @(negedge clk);
    while (uart_tx !== 1'b0 && waited < max_wait) begin
      waited++;
      @(negedge clk);
    end
    n_checks++;
    if (uart_tx !== 1'b0) begin
      n_fail++;
      $display("FAIL %s: start bit not seen within %0d cycles (line=%b, required 0)",
               name, max_wait, uart_tx);
    end else begin
      for (int i = 0; i < FRAME; i++) begin
        if (i > 0) @(negedge clk);
        if (i < DIVISOR)          exp_bit = 1'b0;
        else if (i < 9 * DIVISOR) exp_bit = b[(i / DIVISOR) - 1];
        else                      exp_bit = 1'b1;
        if (uart_tx !== exp_bit && bad < 0) begin
          bad = i;
          got = uart_tx;
        end
      end
      if (bad >= 0) begin
        n_fail++;
        $display("FAIL %s: frame cycle %0d line=%b required %b", name, bad, got, ~got);
      end else begin
        $display("frame 0x%02h %s complete", b, name);
      end
    end
  endtask

  task automatic check_idle(input int cycles, input string name);
    int bad = -1;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (uart_tx !== 1'b1 && bad < 0) bad = i;
    end
    n_checks++;
    if (bad >= 0) begin
      n_fail++;
      $display("FAIL %s: line low at idle cycle %0d, required 1", name, bad);
    end
  endtask

  initial begin
    logic [31:0] rd;
    logic        rdy;

    vecs[0] = '{1'b0, 1'b1, 4'h4, 32'h0,        32'h2, "status_reset"};
    vecs[1] = '{1'b0, 1'b1, 4'h0, 32'h0,        32'h0, "txdata_read"};
    vecs[2] = '{1'b0, 1'b1, 4'h8, 32'h0,        32'h0, "unmapped_8_read"};
    vecs[3] = '{1'b0, 1'b1, 4'hC, 32'h0,        32'h0, "unmapped_c_read"};
    vecs[4] = '{1'b1, 1'b0, 4'h8, 32'hFF,       32'h0, "unmapped_write"};
    vecs[5] = '{1'b0, 1'b1, 4'h4, 32'h0,        32'h2, "status_after_unmapped"};
    vecs[6] = '{1'b1, 1'b0, 4'h4, 32'hFFFFFFFF, 32'h0, "status_write"};
    vecs[7] = '{1'b0, 1'b1, 4'h5, 32'h0,        32'h2, "status_addr5"};
    vecs[8] = '{1'b0, 1'b1, 4'h7, 32'h0,        32'h2, "status_addr7"};
    vecs[9] = '{1'b0, 1'b1, 4'h3, 32'h0,        32'h0, "txdata_addr3"};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_uart_tx", {31'h0, uart_tx}, 32'h1);
    check("rst_mem_ready", {31'h0, mem_ready}, 32'h0);
    check("rst_data_out", data_out, 32'h0);
    reset_n = 1'b1;
    @(negedge clk);

    // Register map vectors: one-cycle ack, then ack and data drop to 0.
    for (int v = 0; v < 10; v++) begin
      bus_access(vecs[v].we, vecs[v].re, vecs[v].addr, vecs[v].wdata, rd, rdy);
      check({vecs[v].name, "_ready"}, {31'h0, rdy}, 32'h1);
      check(vecs[v].name, rd, vecs[v].exp_data);
      @(negedge clk);
      check({vecs[v].name, "_ready_drop"}, {31'h0, mem_ready}, 32'h0);
      check({vecs[v].name, "_data_drop"}, data_out, 32'h0);
    end
    check("line_idle_after_regs", {31'h0, uart_tx}, 32'h1);

    // Single frame 0x55: line still high at N+1, start bit from N+2.
    write_reg(4'h0, 32'h55);
    check("line_high_n1", {31'h0, uart_tx}, 32'h1);
    check_frame(8'h55, 0, "frame_55");
    @(negedge clk);
    read_status("status_after_55", 32'h2);

    // Three back-to-back frames with no idle gap.
    fork
      begin
        check_frame(8'h41, 50, "frame_41");
        check_frame(8'h42, 0,  "frame_42");
        check_frame(8'h43, 0,  "frame_43");
      end
      begin
        write_enable = 1'b1;
        address      = 4'h0;
        data_in      = 32'h41;
        @(negedge clk);
        data_in      = 32'h42;
        @(negedge clk);
        data_in      = 32'h43;
        @(negedge clk);
        write_enable = 1'b0;
        data_in      = 32'h0;
        read_status("status_3_queued", 32'h204);
      end
    join
    // Still in the last stop bit at this sample edge, idle afterwards.
    read_status("status_last_stop", 32'h6);
    read_status("status_idle", 32'h2);

    // Overflow: one frame in flight, then nine writes; the ninth is dropped.
    fork
      begin
        check_frame(8'hA5, 50, "frame_a5");
        for (int i = 0; i < 8; i++) check_frame(8'h10 + 8'(i), 0, "frame_burst");
        check_idle(3 * DIVISOR, "no_ninth_frame");
      end
      begin
        write_reg(4'h0, 32'hA5);
        repeat (2) @(negedge clk);
        write_enable = 1'b1;
        address      = 4'h0;
        for (int i = 0; i < 9; i++) begin
          data_in = 32'h10 + i;
          @(negedge clk);
        end
        write_enable = 1'b0;
        data_in      = 32'h0;
        read_status("status_full_ovf", 32'h80D);
      end
    join
    read_status("status_ovf_sticky", 32'hA);
    write_reg(4'h4, 32'h8);
    read_status("status_ovf_cleared", 32'h2);

    // Reset in the middle of a data bit discards the frame and the queue.
    write_reg(4'h0, 32'h00);
    write_reg(4'h0, 32'h33);
    repeat (3 * DIVISOR + DIVISOR / 2) @(negedge clk);
    check("pre_reset_low", {31'h0, uart_tx}, 32'h0);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    check("reset_line_high", {31'h0, uart_tx}, 32'h1);
    read_status("status_after_reset", 32'h2);
    check_idle(3 * DIVISOR, "no_frame_after_reset");

    // Read and write together: write wins, data_out stays 0.
    bus_access(1'b1, 1'b1, 4'h0, 32'h7E, rd, rdy);
    check("rw_ready", {31'h0, rdy}, 32'h1);
    check("rw_data_out", rd, 32'h0);
    check_frame(8'h7E, 5, "frame_7e");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
